// File: rtl/keccak_squeeze_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keccak_squeeze_buffer: gathers the rate lanes from the slice-parallel       |
// | Keccak state RAM and streams them out as OUT_WIDTH-bit words.               |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module keccak_squeeze_buffer #(
  parameter int PARALLEL_SLICES = 16,
  parameter int RATE_LANES      = 17,
  parameter int OUT_WIDTH       = 32,
  localparam int DATAPATH_WIDTH = 25 * PARALLEL_SLICES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      load_hash,
  output logic [31:0]               raddr,
  input  logic [DATAPATH_WIDTH-1:0] state_dout,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      block_done
);

  localparam int NUM_SUB_ROUNDS = 64 / PARALLEL_SLICES;
  localparam int WORDS          = RATE_LANES * 64 / OUT_WIDTH;
  localparam int RC_W           = $clog2(NUM_SUB_ROUNDS + 1);
  localparam int WC_W           = $clog2(WORDS + 1);
  localparam int BUF_W          = RATE_LANES * 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_TAIL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                             state_q, state_d;
  logic [RC_W-1:0]                    rd_cnt_q, rd_cnt_d;
  logic [WC_W-1:0]                    word_cnt_q, word_cnt_d;
  logic                               cap_valid_q;
  logic [RC_W-1:0]                    cap_addr_q;
  logic [RATE_LANES-1:0][63:0]        lane_buf_q;
  logic [BUF_W-1:0]                   lane_flat;
  logic [OUT_WIDTH-1:0]               word_sel;
  logic                               last_word;

  // Lane 0 occupies the least significant 64 bits, so words fall out little-endian.
  assign lane_flat = lane_buf_q;
  assign word_sel  = lane_flat[32'(word_cnt_q) * OUT_WIDTH +: OUT_WIDTH];
  assign last_word = (word_cnt_q == WC_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      word_cnt_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      word_cnt_q  <= word_cnt_d;
      cap_valid_q <= (state_q == S_READ);
      cap_addr_q  <= rd_cnt_q;
    end
  end

  // RAM data lags its address by one cycle; the (valid, addr) pair tracks it.
  always_ff @(posedge clk) begin
    if (cap_valid_q) begin
      for (int i = 0; i < RATE_LANES; i++) begin
        lane_buf_q[i][32'(cap_addr_q) * PARALLEL_SLICES +: PARALLEL_SLICES]
          <= state_dout[i * PARALLEL_SLICES +: PARALLEL_SLICES];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    word_cnt_d = word_cnt_q;
    load_hash  = 1'b0;
    raddr      = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = (state_q != S_IDLE);
    block_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        rd_cnt_d   = '0;
        word_cnt_d = '0;
        if (start) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        load_hash = 1'b1;
        raddr     = 32'(rd_cnt_q);
        if (rd_cnt_q == RC_W'(NUM_SUB_ROUNDS - 1)) begin
          rd_cnt_d = '0;
          state_d  = S_TAIL;
        end else begin
          rd_cnt_d = rd_cnt_q + RC_W'(1);
        end
      end
      S_TAIL: begin
        word_cnt_d = '0;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = word_sel;
        out_last  = last_word;
        if (out_ready) begin
          if (last_word) begin
            word_cnt_d = '0;
            state_d    = S_DONE;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end
      S_DONE: begin
        block_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capacity lanes come out of the RAM alongside the rate and are dropped here.
  if (RATE_LANES < 25) begin : g_discard
    logic unused_lanes;
    assign unused_lanes = ^state_dout[DATAPATH_WIDTH-1:RATE_LANES*PARALLEL_SLICES];
  end

endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze_buffer.sv
`default_nettype none
// Bench for keccak_squeeze_buffer: timing table, word table, backpressure,
// start-while-busy, resets, and a parameter sweep.
module tb_keccak_squeeze_buffer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              out_ready;
  logic              sw_start;
  logic              load_hash;
  logic [31:0]       raddr;
  logic [25*16-1:0]  sdout;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              block_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got [0:67];
  logic        got_last [0:67];
  int          got_n, dones, stall_err, idle_err;
  logic        timed_out;

  always #5 clk = ~clk;

  function automatic logic [63:0] lane_val(input int i);
    return {32'hFFFF0000 | 32'(i), 32'h00001000 | 32'(i)};
  endfunction

  function automatic logic [31:0] exp_word(input int n);
    logic [63:0] l;
    l = lane_val(n / 2);
    return (n % 2 == 1) ? l[63:32] : l[31:0];
  endfunction

  keccak_squeeze_buffer #(.PARALLEL_SLICES(16), .RATE_LANES(17), .OUT_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_hash(load_hash), .raddr(raddr),
    .state_dout(sdout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .block_done(block_done));

  always @(posedge clk)
    if (load_hash)
      for (int i = 0; i < 25; i++) sdout[i*16 +: 16] <= 16'(lane_val(i) >> (raddr * 16));

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    localparam int P  = (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 64 : 16;
    localparam int OW = (k == 3) ? 64 : 32;
    localparam int NW = 17 * 64 / OW;
    logic           lh, ov, ol, bz, bd;
    logic [31:0]    ra;
    logic [OW-1:0]  od;
    logic [25*P-1:0] sd;
    logic [17*64-1:0] flat;
    int             reads = 0, addr_err = 0, nw = 0, data_err = 0, dn = 0;
    logic [63:0]    w0 = '0;

    keccak_squeeze_buffer #(.PARALLEL_SLICES(P), .RATE_LANES(17), .OUT_WIDTH(OW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .load_hash(lh), .raddr(ra),
      .state_dout(sd), .out_data(od), .out_valid(ov), .out_ready(1'b1),
      .out_last(ol), .busy(bz), .block_done(bd));

    always_comb for (int i = 0; i < 17; i++) flat[i*64 +: 64] = lane_val(i);

    always @(posedge clk)
      if (lh)
        for (int i = 0; i < 25; i++) sd[i*P +: P] <= P'(lane_val(i) >> (ra * P));

    always @(negedge clk) begin
      if (lh) begin
        if (ra != 32'(reads)) addr_err++;
        reads++;
      end
      if (ov) begin
        if (od != flat[nw*OW +: OW] || ol != (nw == NW - 1)) data_err++;
        if (nw == 0) w0 = 64'(od);
        nw++;
      end
      if (bd) dn++;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
  endtask

  // mode 0: ready always; mode 1: random stalls 0-5; mode 2: ready always, start held while busy
  task automatic collect(input int mode, input int stop_at, output int cyc);
    int          stall;
    logic [31:0] prev_data;
    logic        prev_stalled;
    logic        seen_done;
    got_n = 0; dones = 0; stall_err = 0; idle_err = 0;
    stall = 0; prev_data = '0; prev_stalled = 1'b0; seen_done = 1'b0; cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        if (stall > 0) begin out_ready = 1'b0; stall--; end
        else begin out_ready = 1'b1; stall = $urandom_range(0, 5); end
      end else begin
        out_ready = 1'b1;
      end
      start = (mode == 2) ? busy : 1'b0;
      if (prev_stalled && out_data !== prev_data) stall_err++;
      if (block_done) begin dones++; seen_done = 1'b1; break; end
      if (out_valid && out_ready) begin
        if (got_n < 68) begin got[got_n] = out_data; got_last[got_n] = out_last; end
        got_n++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_data    = out_data;
      if (stop_at > 0 && got_n == stop_at) break;
    end
    if (stop_at == 0) begin
      timed_out = !seen_done;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (block_done) dones++;
        if (busy) idle_err++;
      end
    end
  endtask

  task automatic verify_block(input string nm);
    int mism, lerr;
    mism = 0; lerr = 0;
    for (int n = 0; n < 34 && n < got_n; n++) begin
      if (got[n] !== exp_word(n)) mism++;
      if (got_last[n] !== (n == 33)) lerr++;
    end
    check({nm, " words"}, 64'(got_n), 64'd34);
    check({nm, " data"}, 64'(mism), 64'd0);
    check({nm, " last"}, 64'(lerr), 64'd0);
    check({nm, " done_count"}, 64'(dones), 64'd1);
    check({nm, " timeout"}, 64'(timed_out), 64'd0);
    check({nm, " idle_after"}, 64'(idle_err), 64'd0);
    check({nm, " stall_hold"}, 64'(stall_err), 64'd0);
  endtask

  task automatic check_sweep(input string nm, input int reads, input int exp_reads,
                             input int nw, input int exp_nw, input int data_err,
                             input int addr_err, input logic [63:0] w0,
                             input logic [63:0] exp_w0, input int dn);
    check({nm, " reads"}, 64'(reads), 64'(exp_reads));
    check({nm, " raddr_seq"}, 64'(addr_err), 64'd0);
    check({nm, " words"}, 64'(nw), 64'(exp_nw));
    check({nm, " data"}, 64'(data_err), 64'd0);
    check({nm, " word0"}, w0, exp_w0);
    check({nm, " done"}, 64'(dn), 64'd1);
  endtask

  typedef struct {
    logic        lh;
    logic [31:0] ra;
    logic        ov;
    logic        bz;
  } tvec_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } wvec_t;

  initial begin
    tvec_t tv [6];
    wvec_t wv [6];
    int    cyc, bd;
    logic  all_done;

    tv[0] = '{1'b1, 32'd0, 1'b0, 1'b1};
    tv[1] = '{1'b1, 32'd1, 1'b0, 1'b1};
    tv[2] = '{1'b1, 32'd2, 1'b0, 1'b1};
    tv[3] = '{1'b1, 32'd3, 1'b0, 1'b1};
    tv[4] = '{1'b0, 32'd0, 1'b0, 1'b1};
    tv[5] = '{1'b0, 32'd0, 1'b1, 1'b1};
    wv[0] = '{0,  32'h00001000, 1'b0};
    wv[1] = '{1,  32'hFFFF0000, 1'b0};
    wv[2] = '{2,  32'h00001001, 1'b0};
    wv[3] = '{3,  32'hFFFF0001, 1'b0};
    wv[4] = '{20, 32'h0000100A, 1'b0};
    wv[5] = '{33, 32'hFFFF0010, 1'b1};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; sw_start = 1'b0;
    #3;
    check("reset load_hash", 64'(load_hash), 64'd0);
    check("reset raddr", 64'(raddr), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_valid/last", 64'({out_valid, out_last}), 64'd0);
    check("reset busy/done", 64'({busy, block_done}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    // Basic block: cycle-by-cycle read timing, then the drained words
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("timing[%0d] load_hash", k + 1), 64'(load_hash), 64'(tv[k].lh));
      check($sformatf("timing[%0d] raddr", k + 1), 64'(raddr), 64'(tv[k].ra));
      check($sformatf("timing[%0d] out_valid", k + 1), 64'(out_valid), 64'(tv[k].ov));
      check($sformatf("timing[%0d] busy", k + 1), 64'(busy), 64'(tv[k].bz));
    end
    collect(0, 0, cyc);
    verify_block("basic");
    check("basic throughput cycles", 64'(cyc), 64'd35);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("word[%0d] data", wv[i].idx), 64'(got[wv[i].idx]), 64'(wv[i].data));
      check($sformatf("word[%0d] last", wv[i].idx), 64'(got_last[wv[i].idx]), 64'(wv[i].last));
    end

    start_pulse();
    collect(1, 0, cyc);
    verify_block("backpressure");

    start_pulse();
    collect(2, 0, cyc);
    verify_block("start_while_busy");

    // Reset in the middle of READ
    start_pulse();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_read load_hash", 64'(load_hash), 64'd0);
    check("rst_read raddr/busy", 64'({raddr, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_read stays idle", 64'(busy), 64'd0);

    // Reset in the middle of DRAIN, right after word 10 is accepted
    start_pulse();
    collect(0, 11, cyc);
    check("rst_drain words_before", 64'(got_n), 64'd11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drain out_valid", 64'(out_valid), 64'd0);
    check("rst_drain out_data", 64'(out_data), 64'd0);
    check("rst_drain busy/last", 64'({busy, out_last}), 64'd0);
    bd = 0;
    repeat (3) begin
      @(negedge clk);
      if (block_done) bd++;
    end
    check("rst_drain no done", 64'(bd), 64'd0);
    rst_n = 1'b1;
    start_pulse();
    collect(0, 0, cyc);
    verify_block("after_rst");

    // Parameter sweep
    @(negedge clk);
    sw_start = 1'b1;
    @(negedge clk);
    sw_start = 1'b0;
    all_done = 1'b0;
    for (int c = 0; c < 400 && !all_done; c++) begin
      @(negedge clk);
      all_done = (g_sweep[0].dn > 0) && (g_sweep[1].dn > 0) &&
                 (g_sweep[2].dn > 0) && (g_sweep[3].dn > 0);
    end
    check("sweep completed", 64'(all_done), 64'd1);
    repeat (3) @(negedge clk);
    check_sweep("P1", g_sweep[0].reads, 64, g_sweep[0].nw, 34, g_sweep[0].data_err,
                g_sweep[0].addr_err, g_sweep[0].w0, 64'h00001000, g_sweep[0].dn);
    check_sweep("P4", g_sweep[1].reads, 16, g_sweep[1].nw, 34, g_sweep[1].data_err,
                g_sweep[1].addr_err, g_sweep[1].w0, 64'h00001000, g_sweep[1].dn);
    check_sweep("P64", g_sweep[2].reads, 1, g_sweep[2].nw, 34, g_sweep[2].data_err,
                g_sweep[2].addr_err, g_sweep[2].w0, 64'h00001000, g_sweep[2].dn);
    check_sweep("OW64", g_sweep[3].reads, 4, g_sweep[3].nw, 17, g_sweep[3].data_err,
                g_sweep[3].addr_err, g_sweep[3].w0, 64'hFFFF000000001000, g_sweep[3].dn);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keccak_squeeze_buffer.md
Name: keccak_squeeze_buffer

Overview:
- Downstream consumer of the slice-parallel Keccak state RAM during the squeeze phase.
- After a permutation completes, it walks the RAM's slice-group read addresses and reassembles the 17 rate lanes (1088 bits, SHAKE256 rate) from slice-interleaved RAM output words into a lane buffer.
- It then streams the buffer out as OUT_WIDTH-bit words over a valid/ready handshake to the HQC sampler/consumer.
- It pulses a done flag so the Keccak controller can start the next permutation.

Parameters:
- PARALLEL_SLICES, 16, slices read per RAM access; one of 1, 2, 4, 8, 16, 32, 64.
- RATE_LANES, 17, number of 64-bit lanes squeezed per block.
- OUT_WIDTH, 32, output word width; must divide 64.
- Derived localparams: DATAPATH_WIDTH = 25*PARALLEL_SLICES; NUM_SUB_ROUNDS = 64/PARALLEL_SLICES; WORDS = RATE_LANES*64/OUT_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: state holds a fresh squeeze block.
- load_hash  out  1  read request to state RAM (read enable, no z0 fixup).
- raddr  out  32  slice-group read address, 0..NUM_SUB_ROUNDS-1.
- state_dout  in  DATAPATH_WIDTH  RAM read data, valid the cycle after its raddr.
- out_data  out  OUT_WIDTH  squeezed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- out_last  out  1  qualifies the final word of the block.
- busy  out  1  high in any state but IDLE.
- block_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All outputs are 0: load_hash, raddr, out_data, out_valid, out_last, busy, block_done. Read counter and word counter are 0. Lane buffer contents are don't-care.
- RAM data format: during load_hash, state_dout bits [(i+1)*P-1 -: P] hold lane i (i = x+5y). Bit j of that field is lane bit raddr*P+j, in natural (unrotated) order.
- IDLE: start=1 at edge T moves to READ. start is ignored in every other state (no queueing).
- READ:
  - Lasts NUM_SUB_ROUNDS cycles, T+1 .. T+NUM_SUB_ROUNDS.
  - load_hash=1; raddr = k in the k-th cycle, counting from 0.
  - The capture pipeline holds a registered (valid, addr) pair. On the cycle after each read, lanes 0..RATE_LANES-1 of state_dout are written into lane_buf[i][addr*P +: P].
  - Lanes 17..24 are discarded.
  - After the last address, moves to TAIL.
- TAIL: one cycle. load_hash=0, raddr=0. The final capture completes. Moves to DRAIN with word index w=0.
- DRAIN:
  - out_valid=1; out_data = word w.
  - Word w is lane (w*OUT_WIDTH)/64, bits ((w*OUT_WIDTH) mod 64) +: OUT_WIDTH. Ordering is little-endian within a lane, lanes ascending.
  - First out_valid is in cycle T+NUM_SUB_ROUNDS+2.
  - w advances only on out_valid & out_ready. out_data is held stable while out_ready=0.
  - out_last = (w == WORDS-1).
  - On acceptance of the last word, moves to DONE.
- DONE: block_done=1 for exactly one cycle, busy still 1. Next cycle returns to IDLE. A start in the DONE cycle is ignored. The earliest accepted start is in the IDLE cycle after DONE.
- Throughput: one word per cycle under continuous out_ready.
- No combinational path from out_ready to out_valid or out_data.
- PARALLEL_SLICES=64: READ is one cycle; the rest is unchanged.
- Reset asserted mid-READ or mid-DRAIN:
  - Immediate return to IDLE with all outputs 0.
  - No block_done.
  - Partial words are lost.
- Counter widths: read counter is clog2(NUM_SUB_ROUNDS+1) bits; word counter is clog2(WORDS+1) bits. raddr is zero-extended to 32 bits.

Test Plan:
- Reset: hold rst_n=0 mid-simulation, including mid-clock → all outputs 0 immediately. Release, then pulse start → busy rises the next cycle.
- Basic block (P=16, OUT_WIDTH=32): RAM model holds lane i = {32'hFFFF0000|i, 32'h00001000|i}; pulse start, out_ready=1.
  - Expect raddr 0,1,2,3 with load_hash=1 for 4 cycles.
  - First out_valid 6 cycles after start.
  - 34 words: word0=32'h00001000, word1=32'hFFFF0000, word33=32'hFFFF0010 with out_last=1.
  - block_done pulse on the next cycle.
- Backpressure: same stimulus, out_ready toggled pseudo-randomly with stalls of 0-5 cycles → identical 34-word sequence, out_data stable during every stall, exactly one block_done.
- Start during busy: extra start pulses during READ, DRAIN and DONE → ignored; exactly 34 words and one block_done per accepted start.
- Reset mid-drain: assert rst_n=0 after word 10 is accepted → out_valid drops asynchronously, no block_done. A new start then yields a full 34-word block from word 0.
- Parameter sweep P=1, 4, 64 and OUT_WIDTH=64 with the same lane pattern → correct reads and output:
  - READ lasts 64, 16 and 1 cycles respectively.
  - With OUT_WIDTH=64: 17 words, word0=64'hFFFF000000001000.
